// File: rtl/pipeline_skid_reg.sv
// -----------------------------------------------------------------------------
// pipeline_skid_reg
//
// This is an elastic pipeline stage register with two entries, main and skid.
// It carries a packed payload between two pipeline stages, for example
// instr/PC/PC+4 between fetch and decode.
//
// in_ready comes straight from a flop: it is the inverse of the skid-valid bit.
// As a result, no combinational path runs from out_ready to in_ready, and none
// runs from in_valid to out_valid. A flush kills both entries on the next
// edge. Two saturating counters record stall cycles and effective flushes.
//
// Handshake: a beat moves on a channel on any rising edge where valid and
// ready are both 1. The sender holds valid and data until that edge. The
// sender must not make valid depend on ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage can accept this cycle (registered)
//   in_data    in   upstream payload, WIDTH bits
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream accepts this cycle
//   out_data   out  main-entry payload, 0 when out_valid = 0
//   stall_cnt  out  saturating count of out_valid && !out_ready && !flush
//   flush_cnt  out  saturating count of flush cycles with a valid main entry
//   clr_cnt    in   synchronous clear of both counters (beats increment)
//   dbg_state  out  occupancy state {skid_valid, main_valid} for observation
// -----------------------------------------------------------------------------
module pipeline_skid_reg #(
    parameter int WIDTH     = 96,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    input  logic                 clr_cnt,
    output logic [1:0]           dbg_state
);

    // The encoding is {skid_valid, main_valid}, so each valid bit is simply
    // one bit of the state register. 2'b10 (skid without main) is illegal.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_main_data;
    logic [WIDTH-1:0]     r_skid_data;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_xfer;
    logic w_stall;
    logic w_flush_hit;

    assign w_main_valid = r_state[0];
    assign w_skid_valid = r_state[1];

    assign w_accept    = in_valid && !w_skid_valid;
    assign w_xfer      = w_main_valid && out_ready;
    assign w_stall     = w_main_valid && !out_ready && !flush;
    assign w_flush_hit = flush && w_main_valid;

    // ---------------------------------------------------------------------
    // Occupancy FSM and data registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // A transfer in this cycle has already been sampled downstream.
            // An accept in this cycle belongs to the wrong path, so it is
            // dropped.
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= in_data;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_xfer) begin
                        r_main_data <= in_data;
                    end else if (w_accept) begin
                        // Downstream stalled while upstream still had a beat.
                        // Park that beat in skid, which drops in_ready.
                        r_skid_data <= in_data;
                        r_state     <= ST_FULL;
                    end else if (w_xfer) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_xfer) begin
                        r_main_data <= r_skid_data;
                        r_skid_data <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main_data <= '0;
                    r_skid_data <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Saturating performance counters; clear beats increment
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_hit && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: every one is a flop or a flop gated by a flop
    // ---------------------------------------------------------------------
    assign in_ready  = !w_skid_valid;
    assign out_valid = w_main_valid;
    assign out_data  = w_main_valid ? r_main_data : '0;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign dbg_state = r_state;

    // The skid entry can never hold data while the main entry is empty.
    a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
        !(w_skid_valid && !w_main_valid));

endmodule

// File: tb/tb_pipeline_skid_reg.sv
module tb_pipeline_skid_reg;

  localparam int W  = 96;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic          clr_cnt;
  logic [1:0]    dbg_state;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  pipeline_skid_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .clr_cnt   (clr_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // Advance one active edge, then settle 1 ns so that outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  // Check several outputs together. Each field counts as one comparison.
  task automatic chk_out(input string name, input logic ev, input logic [W-1:0] ed,
                         input logic er);
    checks++;
    if (out_valid !== ev) begin
      errors++;
      $display("FAIL %s out_valid: got %0b want %0b", name, out_valid, ev);
    end
    checks++;
    if (out_data !== ed) begin
      errors++;
      $display("FAIL %s out_data: got %h want %h", name, out_data, ed);
    end
    checks++;
    if (in_ready !== er) begin
      errors++;
      $display("FAIL %s in_ready: got %0b want %0b", name, in_ready, er);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] es, input logic [CW-1:0] ef);
    checks++;
    if (stall_cnt !== es) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, es);
    end
    checks++;
    if (flush_cnt !== ef) begin
      errors++;
      $display("FAIL %s flush_cnt: got %0d want %0d", name, flush_cnt, ef);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'($urandom_range(1, 255));
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    step();
    step();
    // All inputs are ignored while rst is high.
    chk_out("reset", 1'b0, '0, 1'b1);
    chk_cnt("reset", 4'd0, 4'd0);
    checks++;
    if (dbg_state !== 2'b00) begin
      errors++;
      $display("FAIL reset dbg_state: got %b want 00", dbg_state);
    end
    idle_inputs();
    rst = 1'b0;
    step();
    chk_out("reset_release", 1'b0, '0, 1'b1);
  endtask

  task automatic test_stream();
    logic [W-1:0] exp;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      exp_q.push_back(W'(i));
      step();
      exp = exp_q.pop_front();
      chk_out($sformatf("stream_%0d", i), 1'b1, exp, 1'b1);
    end
    in_valid = 1'b0;
    in_data  = '0;
    step();
    chk_out("stream_drain", 1'b0, '0, 1'b1);
    chk_cnt("stream", 4'd0, 4'd0);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'(32'hA);
    step();                                  // A lands in main
    chk_out("bp_a", 1'b1, W'(32'hA), 1'b1);
    out_ready = 1'b0;
    in_data   = W'(32'hB);
    step();                                  // B lands in skid, 1 stall
    chk_out("bp_b_skid", 1'b1, W'(32'hA), 1'b0);
    checks++;
    if (dbg_state !== 2'b11) begin
      errors++;
      $display("FAIL bp_full dbg_state: got %b want 11", dbg_state);
    end
    chk_cnt("bp_stall1", 4'd1, 4'd0);
    in_data = W'(32'hC);
    step();                                  // C held upstream, 2 stalls
    chk_out("bp_hold", 1'b1, W'(32'hA), 1'b0);
    chk_cnt("bp_stall2", 4'd2, 4'd0);
    out_ready = 1'b1;
    step();                                  // A out, B to main, C still held
    chk_out("bp_b_out", 1'b1, W'(32'hB), 1'b1);
    step();                                  // B out, C accepted into main
    chk_out("bp_c_out", 1'b1, W'(32'hC), 1'b1);
    in_valid = 1'b0;
    in_data  = '0;
    step();                                  // C out, empty
    chk_out("bp_empty", 1'b0, '0, 1'b1);
    chk_cnt("bp_final", 4'd2, 4'd0);
    idle_inputs();
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'h5);
    step();                                  // 5 in main, no stall counted yet
    in_data = W'(32'h6);
    step();                                  // 6 in skid, stall 3
    chk_out("ff_full", 1'b1, W'(32'h5), 1'b0);
    flush   = 1'b1;
    in_data = W'(32'h7);
    step();                                  // flush: everything gone
    chk_out("ff_flushed", 1'b0, '0, 1'b1);
    chk_cnt("ff_cnt", 4'd3, 4'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    chk_out("ff_no_7", 1'b0, '0, 1'b1);
    idle_inputs();
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_out("fe", 1'b0, '0, 1'b1);
    chk_cnt("fe_cnt", 4'd3, 4'd1);
    idle_inputs();
  endtask

  task automatic test_saturation();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk_cnt("sat_clr0", 4'd0, 4'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'h11);
    step();                                  // BUSY, count still 0
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk_cnt("sat_14", 4'd14, 4'd0);
    end
    chk_cnt("sat_15", 4'd15, 4'd0);
    chk_out("sat_held", 1'b1, W'(32'h11), 1'b1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk_cnt("sat_clear", 4'd0, 4'd0);
    step();
    chk_cnt("sat_reinc", 4'd1, 4'd0);
    // Flush together with a clear: the clear wins and the flush is not counted.
    flush   = 1'b1;
    clr_cnt = 1'b1;
    step();
    flush   = 1'b0;
    clr_cnt = 1'b0;
    chk_cnt("flush_clr", 4'd0, 4'd0);
    chk_out("flush_clr", 1'b0, '0, 1'b1);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'h21);
    step();
    in_data = W'(32'h22);
    step();                                  // FULL, 1 stall
    chk_out("ar_full", 1'b1, W'(32'h21), 1'b0);
    #2;
    rst = 1'b1;                              // mid-cycle, between edges
    #1;
    chk_out("ar_immediate", 1'b0, '0, 1'b1);
    chk_cnt("ar_immediate", 4'd0, 4'd0);
    step();
    step();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(32'h33);
    out_ready = 1'b1;
    step();
    chk_out("ar_resume", 1'b1, W'(32'h33), 1'b1);
    in_valid = 1'b0;
    in_data  = '0;
    step();
    chk_out("ar_drain", 1'b0, '0, 1'b1);
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_empty();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_reg.md
# pipeline_skid_reg

Parametrised, elastic pipeline stage register for the pipelined core: the valid/ready successor to the fixed-width enable/flush stage registers. It holds a generic packed payload (e.g. instr/PC/PC+4 between fetch and decode) in a two-entry main/skid structure. Upstream stalls are driven by a registered ready, so there is no combinational ready path across stages. The block also has a synchronous flush and saturating stall/flush performance counters.

## Interface
- WIDTH, 96: payload width in bits (packed stage fields).
- CNT_WIDTH, 16: width of each performance counter.

- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (wrong-path squash).
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept this cycle; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload of main entry; forced to 0 when out_valid=0.
- stall_cnt  out  CNT_WIDTH  cycles with out_valid && !out_ready && !flush; saturating.
- flush_cnt  out  CNT_WIDTH  flush cycles that killed at least one valid entry; saturating.
- clr_cnt  in  1  synchronous clear of both counters.

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry has a valid bit and a WIDTH data register.
- State is encoded by the valid bits: EMPTY (main=0, skid=0), BUSY (main=1, skid=0), FULL (main=1, skid=1). main=0 with skid=1 is illegal.
- in_ready = !skid_valid. out_valid = main_valid.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- EMPTY: on accept, main<=in_data and go to BUSY. Otherwise stay.
- BUSY:
  - accept and transfer: main<=in_data, stay in BUSY.
  - accept only: skid<=in_data, go to FULL.
  - transfer only: go to EMPTY.
  - neither: hold.
- FULL: no accept is possible. On transfer: main<=skid, skid_valid<=0, go to BUSY. Otherwise hold.
- flush has highest priority (below rst):
  - Next state is EMPTY, and both data registers are cleared to 0.
  - An output transfer in the flush cycle still completes; downstream keeps what it sampled.
  - An input handshake in the flush cycle is discarded even though in_ready was 1. The upstream entry is wrong-path by definition.
- Entries are never reordered or duplicated. Output order equals accept order.
- Counters:
  - stall_cnt increments when out_valid && !out_ready && !flush.
  - flush_cnt increments when flush && main_valid.
  - Both saturate at 2^CNT_WIDTH-1.
  - clr_cnt zeroes both counters and takes priority over increment in the same cycle.

## Timing
- Latency: 1 cycle from input accept to out_valid when EMPTY.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready depends only on flops. There is no combinational path in_valid->out_valid or out_ready->in_ready. out_data is gated by out_valid only.
- After out_ready drops, in_ready falls on the edge where the skid entry loads, one cycle later. The entry accepted in that cycle lands in skid.
- Reset, asynchronous on rst assertion, possible mid-operation:
  - main_valid=skid_valid=0, both data registers=0, counters=0.
  - Outputs immediately: out_valid=0, out_data=0, in_ready=1, stall_cnt=0, flush_cnt=0.
  - All inputs are ignored while rst=1. Normal operation resumes on the first edge after deassertion.
- Flush while FULL: both entries are lost. The next cycle shows out_valid=0 and in_ready=1.
- Flush together with clr_cnt: counters clear, and the flush is not counted.

## Test plan
- Reset then stream: rst pulse. Then in_data=0x1,0x2,0x3 on consecutive cycles with out_ready=1. Required: out_data 0x1,0x2,0x3 one cycle later each; in_ready stays 1; stall_cnt=0.
- Backpressure: stream 0xA,0xB,0xC with out_ready=0 starting from 0xA's output cycle. Required:
  - 0xB goes to skid and in_ready=0 next cycle.
  - 0xC is held upstream.
  - On out_ready=1, outputs are 0xA,0xB,0xC in order with no loss.
  - stall_cnt equals the number of stalled cycles.
- Flush while FULL: fill with 0x5,0x6, then pulse flush with in_valid=1, in_data=0x7. Required: next cycle out_valid=0, out_data=0, in_ready=1; 0x7 is never emitted; flush_cnt=1.
- Flush while EMPTY: pulse flush. Required: flush_cnt unchanged; out_valid=0.
- Saturation and clear, CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt stops at 15. Then clr_cnt=1 for one cycle while still stalled. Required: stall_cnt=0, then increments to 1 the following cycle.
- Async reset mid-transfer: assert rst between clock edges while FULL. Required: out_valid=0, out_data=0, in_ready=1 before the next edge; after release, the first accepted entry appears after 1 cycle.
